piso_serializer_hs: RTL

Parametrised parallel-in/serial-out serializer with a valid/ready input handshake, a runtime-selectable bit order and an external bit-rate enable. It accepts DATA_W-bit words and emits one bit per enabled cycle, flagging frame start and frame completion. Words can be accepted back-to-back with no idle gap. It sits between a word-oriented producer and a serial line driver, and supersedes the fixed 4-bit, LSB-only shift register.

---
 rtl/piso_serializer_hs.sv | 119 +++++++++++
 1 files changed

// File: rtl/piso_serializer_hs.sv
// Parallel-in/serial-out serializer with valid/ready input handshake,
// runtime-selectable bit order and an external bit-rate enable.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   s_valid/s_ready/s_data  word input handshake (s_ready is combinational)
//   msb_first     bit order, sampled when a word is accepted
//   shift_en      bit-rate strobe; one serial bit advances per enabled cycle
//   ser_out, ser_valid, frame_start  serial outputs (combinational from state)
//   done          registered one-cycle pulse after a frame's last bit
//   frame_count   saturating count of completed frames
module piso_serializer_hs #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              msb_first,
  input  logic              shift_en,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              done,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int unsigned BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0] LAST_CNT = BC_W'(DATA_W - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]        state, state_nxt;
  logic [DATA_W-1:0] shift_reg, shift_reg_nxt;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic              ord, ord_nxt;
  logic              done_nxt;
  logic [CNT_W-1:0]  frame_count_nxt;

  logic last_bit;
  logic accept;

  // Last bit leaving this cycle frees the register for a back-to-back load.
  assign last_bit = (state == SHIFT) && (bit_cnt == '0) && shift_en;
  assign s_ready  = !reset && ((state == IDLE) || last_bit);
  assign accept   = s_valid && s_ready;

  // Serial outputs are a pure function of the registered frame state.
  assign ser_valid   = (state == SHIFT);
  assign ser_out     = (state == SHIFT) && (ord ? shift_reg[DATA_W-1] : shift_reg[0]);
  assign frame_start = (state == SHIFT) && (bit_cnt == LAST_CNT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      ord         <= 1'b0;
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      shift_reg   <= shift_reg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      ord         <= ord_nxt;
      done        <= done_nxt;
      frame_count <= frame_count_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt       = state;
    shift_reg_nxt   = shift_reg;
    bit_cnt_nxt     = bit_cnt;
    ord_nxt         = ord;
    done_nxt        = 1'b0;
    frame_count_nxt = frame_count;

    case (state)
      IDLE: begin
        if (accept) begin
          shift_reg_nxt = s_data;
          ord_nxt       = msb_first;
          bit_cnt_nxt   = LAST_CNT;
          state_nxt     = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (bit_cnt != '0) begin
            // Move the next bit toward the output end, zero fill.
            shift_reg_nxt = ord ? {shift_reg[DATA_W-2:0], 1'b0}
                                : {1'b0, shift_reg[DATA_W-1:1]};
            bit_cnt_nxt   = bit_cnt - BC_W'(1);
          end else begin
            done_nxt = 1'b1;
            if (frame_count != '1) begin
              frame_count_nxt = frame_count + CNT_W'(1);
            end
            if (accept) begin
              shift_reg_nxt = s_data;
              ord_nxt       = msb_first;
              bit_cnt_nxt   = LAST_CNT;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
